mem_port_arbiter: RTL

//  Shares one single-port unified memory between the IF stage (instruction fetch) and MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// load/store (DM). Only one memory transaction is in flight at a time. The
// data side wins contention. A starvation counter forces fetch to win once
// it has been passed over STARVE_MAX times while pending.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   if_req, if_addr                  fetch request (level, held until if_done)
//   if_done, if_rdata                fetch completion pulse, registered word
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_be                  load/store request (level, held until dm_done)
//   dm_done, dm_rdata                load/store completion pulse, load data
//   stall_if, stall_m                combinational stalls for the hazard unit
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be                registered memory request
//   mem_gnt, mem_rvalid, mem_rdata   memory accept / completion / read data
//
// state | meaning
// IDLE  | no transaction; arbitrate among unmasked requesters
// REQ   | mem_req driven, waiting for mem_gnt
// WAIT  | request accepted, waiting for mem_rvalid
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_done,
  output logic [DW-1:0]   dm_rdata,
  output logic            stall_if,
  output logic            stall_m,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arbStateE;

  arbStateE        state;
  arbStateE        stateNext;
  logic            ownerDm;
  logic [CW-1:0]   starveCnt;
  logic            ifLive;
  logic            dmLive;
  logic            starveFull;
  logic            pickDm;
  logic            pickIf;
  logic            finish;

  // A requester whose done pulse is high is still presenting the request it
  // just completed; ignore it for one cycle so it is not issued twice.
  assign ifLive     = if_req && !if_done;
  assign dmLive     = dm_req && !dm_done;
  assign starveFull = (starveCnt == CW'(STARVE_MAX));

  assign stall_if = if_req && !if_done;
  assign stall_m  = dm_req && !dm_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    pickDm    = 1'b0;
    pickIf    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (dmLive && !(ifLive && starveFull)) begin
          pickDm    = 1'b1;
          stateNext = REQ;
        end else if (ifLive) begin
          pickIf    = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        // rvalid without gnt here is a stray response and is dropped
        if (mem_gnt) begin
          if (mem_rvalid) begin
            finish    = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ownerDm   <= 1'b0;
      starveCnt <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_done <= finish && !ownerDm;
      dm_done <= finish && ownerDm;

      if (pickDm) begin
        ownerDm   <= 1'b1;
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (pickIf) begin
        ownerDm   <= 1'b0;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else if (state == REQ && mem_gnt) begin
        mem_req <= 1'b0;
      end

      // mem_we still holds the owner's direction while the transaction completes
      if (finish) begin
        if (ownerDm) begin
          dm_rdata <= mem_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end

      if (pickDm && ifLive && !starveFull) begin
        starveCnt <= starveCnt + CW'(1);
      end else if (pickIf) begin
        starveCnt <= '0;
      end
    end
  end

endmodule
